// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one registered slot toward writeback, loads/stores run a
// req/gnt + rvalid bus transaction with lane steering and sign/zero extension.
module mem_access_stage #(
  parameter int unsigned GNT_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        halt_i,
  input  logic        valid_i,
  output logic        ack_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] result_i,
  input  logic [31:0] rs2_i,
  input  logic        branch_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        ack_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] result_o,
  output logic        branch_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] TO_LAST  = (GNT_TIMEOUT == 0) ? 32'd0 : 32'(GNT_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      r_state;
  logic        r_valid, r_branch, r_misalign, r_bus_err;
  logic [31:0] r_instr, r_pc, r_result, r_rdata, r_tcnt;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        w_is_load, w_is_store, w_misalign, w_mem_op, w_timeout;
  logic [2:0]  w_f3;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rdata, w_load_val, w_fill_result;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_f3       = instr_i[14:12];
  assign w_is_load  = (instr_i[6:0] == OP_LOAD);
  assign w_is_store = (instr_i[6:0] == OP_STORE);
  assign w_misalign = (w_is_load || w_is_store) &&
                      (((w_f3[1:0] == 2'b01) && result_i[0]) ||
                       (w_f3[1] && (result_i[1:0] != 2'b00)));
  assign w_mem_op   = (w_is_load || w_is_store) && !w_misalign;
  assign ack_o      = valid_i && (!r_valid || ack_i) && (r_state == S_IDLE) && !halt_i && !flush_i;
  assign w_timeout  = (GNT_TIMEOUT != 0) && !mem_gnt_i && (r_tcnt == TO_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_i;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << result_i[1:0];
        w_wdata = {4{rs2_i[7:0]}};
      end
      2'b01: begin
        w_be    = result_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{rs2_i[15:0]}};
      end
      default: ;
    endcase
  end

  // A halted response is parked in r_rdata; lane select uses the captured address.
  assign w_rdata = (r_state == S_HOLD) ? r_rdata : mem_rdata_i;
  assign w_byte  = w_rdata[{r_result[1:0], 3'b000} +: 8];
  assign w_half  = r_result[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_load_val = w_rdata;
    case (r_instr[14:12])
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = w_rdata;
    endcase
  end

  assign w_fill_result = ((r_instr[6:0] == OP_LOAD) && !r_bus_err) ? w_load_val : r_result;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_valid     <= 1'b0;
      r_branch    <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_result    <= '0;
      r_rdata     <= '0;
      r_tcnt      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (ack_i) r_valid <= 1'b0;
      if (flush_i) begin
        r_valid  <= 1'b0;
        r_branch <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (ack_o) begin
            r_instr    <= instr_i;
            r_pc       <= pc_i;
            r_result   <= result_i;
            r_branch   <= branch_i;
            r_misalign <= w_misalign;
            r_bus_err  <= 1'b0;
            if (w_mem_op) begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {result_i[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_tcnt      <= '0;
            end else begin
              r_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (flush_i) begin
            r_mem_req <= 1'b0;
            r_state   <= mem_gnt_i ? S_DRAIN : S_IDLE;
          end else if (mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_bus_err <= 1'b1;
            if (halt_i) begin
              r_state <= S_HOLD;
            end else begin
              r_valid <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            if (flush_i) begin
              r_state <= S_IDLE;
            end else if (halt_i) begin
              r_rdata <= mem_rdata_i;
              r_state <= S_HOLD;
            end else begin
              r_valid  <= 1'b1;
              r_result <= w_fill_result;
              r_state  <= S_IDLE;
            end
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_HOLD: begin
          if (flush_i) begin
            r_state <= S_IDLE;
          end else if (!halt_i) begin
            r_valid  <= 1'b1;
            r_result <= w_fill_result;
            r_state  <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mem_rvalid_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_o     = r_valid && !flush_i;
  assign instr_o     = r_instr;
  assign pc_o        = r_pc;
  assign result_o    = r_result;
  assign branch_o    = r_branch;
  assign misalign_o  = r_misalign;
  assign bus_err_o   = r_bus_err;
  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_be_o    = r_mem_be;
  assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: one instance with unbounded grant wait,
// one with GNT_TIMEOUT=4 whose grant is never given.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rstn, flush, halt, valid_in, ack_out, branch_in, ack_in;
  logic [31:0] instr, pc, result, rs2, rdata;
  logic        gnt, rvalid;
  logic        req, we, valid_out, branch_out, misalign, bus_err;
  logic [31:0] addr, wdata, instr_out, pc_out, result_out;
  logic [3:0]  be;

  logic        valid2, ack_out2, req2, we2, valid_out2, branch_out2, misalign2, bus_err2;
  logic [31:0] addr2, wdata2, instr_out2, pc_out2, result_out2;
  logic [3:0]  be2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.GNT_TIMEOUT(0)) u_dut (
    .clk(clk), .rstn_i(rstn), .flush_i(flush), .halt_i(halt),
    .valid_i(valid_in), .ack_o(ack_out), .instr_i(instr), .pc_i(pc),
    .result_i(result), .rs2_i(rs2), .branch_i(branch_in),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_be_o(be),
    .mem_wdata_o(wdata), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
    .mem_rdata_i(rdata), .ack_i(ack_in), .valid_o(valid_out),
    .instr_o(instr_out), .pc_o(pc_out), .result_o(result_out),
    .branch_o(branch_out), .misalign_o(misalign), .bus_err_o(bus_err)
  );

  mem_access_stage #(.GNT_TIMEOUT(4)) u_dut_to (
    .clk(clk), .rstn_i(rstn), .flush_i(flush), .halt_i(halt),
    .valid_i(valid2), .ack_o(ack_out2), .instr_i(instr), .pc_i(pc),
    .result_i(result), .rs2_i(rs2), .branch_i(branch_in),
    .mem_req_o(req2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_be_o(be2),
    .mem_wdata_o(wdata2), .mem_gnt_i(1'b0), .mem_rvalid_i(1'b0),
    .mem_rdata_i(rdata), .ack_i(ack_in), .valid_o(valid_out2),
    .instr_o(instr_out2), .pc_o(pc_out2), .result_o(result_out2),
    .branch_o(branch_out2), .misalign_o(misalign2), .bus_err_o(bus_err2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; halt = 1'b0; valid_in = 1'b0; valid2 = 1'b0;
    instr = '0; pc = '0; result = '0; rs2 = '0; branch_in = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; ack_in = 1'b0;
    #12;
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_result", result_out, 32'd0);
    check_eq("rst_be", 32'(be), 32'd0);
    check_eq("rst_buserr", 32'(bus_err), 32'd0);
    rstn = 1'b1;

    // ALU op passes through with one-cycle latency
    valid_in = 1'b1; instr = 32'h00B50533; pc = 32'h100; result = 32'h1234;
    branch_in = 1'b1; ack_in = 1'b1;
    #1 check_eq("alu_ack", 32'(ack_out), 32'd1);
    tick(); valid_in = 1'b0; branch_in = 1'b0;
    check_eq("alu_valid", 32'(valid_out), 32'd1);
    check_eq("alu_result", result_out, 32'h1234);
    check_eq("alu_instr", instr_out, 32'h00B50533);
    check_eq("alu_branch", 32'(branch_out), 32'd1);
    check_eq("alu_noreq", 32'(req), 32'd0);
    tick();
    check_eq("alu_consumed", 32'(valid_out), 32'd0);

    // LB at 0x1003, granted first request cycle
    instr = 32'h00050583; result = 32'h1003; valid_in = 1'b1;
    #1 check_eq("lb_ack", 32'(ack_out), 32'd1);
    tick(); valid_in = 1'b0; gnt = 1'b1;
    check_eq("lb_req", 32'(req), 32'd1);
    check_eq("lb_addr", addr, 32'h1000);
    check_eq("lb_be", 32'(be), 32'h8);
    check_eq("lb_we", 32'(we), 32'd0);
    tick(); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80000000;
    check_eq("lb_req_drop", 32'(req), 32'd0);
    check_eq("lb_not_yet", 32'(valid_out), 32'd0);
    tick(); rvalid = 1'b0;
    check_eq("lb_valid", 32'(valid_out), 32'd1);
    check_eq("lb_result", result_out, 32'hFFFFFF80);
    tick();

    // SH at 0x2002, grant delayed one cycle
    instr = 32'h00B51023; rs2 = 32'h1234ABCD; result = 32'h2002; valid_in = 1'b1;
    tick(); valid_in = 1'b0;
    check_eq("sh_addr", addr, 32'h2000);
    check_eq("sh_be", 32'(be), 32'hC);
    check_eq("sh_wdata", wdata, 32'hABCDABCD);
    check_eq("sh_we", 32'(we), 32'd1);
    tick(); gnt = 1'b1;
    check_eq("sh_req_held", 32'(req), 32'd1);
    tick(); gnt = 1'b0; rvalid = 1'b1;
    check_eq("sh_req_drop", 32'(req), 32'd0);
    tick(); rvalid = 1'b0;
    check_eq("sh_valid", 32'(valid_out), 32'd1);
    check_eq("sh_result", result_out, 32'h2002);
    tick();

    // misaligned LW: no bus access, one-cycle latency
    instr = 32'h00052503; result = 32'h2001; valid_in = 1'b1;
    tick(); valid_in = 1'b0;
    check_eq("lwm_noreq", 32'(req), 32'd0);
    check_eq("lwm_valid", 32'(valid_out), 32'd1);
    check_eq("lwm_flag", 32'(misalign), 32'd1);
    check_eq("lwm_result", result_out, 32'h2001);
    tick();

    // flush while waiting for rvalid: response drained and dropped
    instr = 32'h00054583; result = 32'h1001; valid_in = 1'b1;
    tick(); valid_in = 1'b0; gnt = 1'b1;
    tick(); gnt = 1'b0; flush = 1'b1;
    #1 check_eq("fl_valid", 32'(valid_out), 32'd0);
    tick(); flush = 1'b0; valid_in = 1'b1; instr = 32'h00B50533; result = 32'h55;
    #1 check_eq("fl_drain_ack", 32'(ack_out), 32'd0);
    tick(); rvalid = 1'b1; rdata = 32'h000000FF;
    #1 check_eq("fl_drain_ack2", 32'(ack_out), 32'd0);
    tick(); rvalid = 1'b0;
    check_eq("fl_dropped", 32'(valid_out), 32'd0);
    #1 check_eq("fl_idle_ack", 32'(ack_out), 32'd1);
    tick(); valid_in = 1'b0;
    check_eq("fl_next_valid", 32'(valid_out), 32'd1);
    check_eq("fl_next_result", result_out, 32'h55);
    tick();

    // LH at 0x3002 with halt across rvalid
    instr = 32'h00051583; result = 32'h3002; valid_in = 1'b1;
    tick(); valid_in = 1'b0; gnt = 1'b1;
    tick(); gnt = 1'b0; halt = 1'b1; rvalid = 1'b1; rdata = 32'h80010000;
    tick(); rvalid = 1'b0; rdata = 32'h0;
    check_eq("hold_valid1", 32'(valid_out), 32'd0);
    tick();
    check_eq("hold_valid2", 32'(valid_out), 32'd0);
    halt = 1'b0;
    tick();
    check_eq("hold_release", 32'(valid_out), 32'd1);
    check_eq("hold_result", result_out, 32'hFFFF8001);
    tick();

    // grant timeout after 4 request cycles
    instr = 32'h00052503; result = 32'h4000; valid2 = 1'b1;
    #1 check_eq("to_ack", 32'(ack_out2), 32'd1);
    tick(); valid2 = 1'b0;
    check_eq("to_req", 32'(req2), 32'd1);
    tick(); tick(); tick();
    check_eq("to_req_c4", 32'(req2), 32'd1);
    check_eq("to_nvalid_c4", 32'(valid_out2), 32'd0);
    tick();
    check_eq("to_req_drop", 32'(req2), 32'd0);
    check_eq("to_valid", 32'(valid_out2), 32'd1);
    check_eq("to_buserr", 32'(bus_err2), 32'd1);
    check_eq("to_result", result_out2, 32'h4000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
